// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned DATA_W_DEF    = 16;
    localparam int unsigned ADDR_W_DEF    = 16;
    localparam int unsigned MEM_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin picker: on a tie the side not granted last wins.
module dmem_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner
);

    always_comb begin
        winner = (req == 2'b11) ? ~ptr : req[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the MEM stage (port 0) and the loader/debug requester (port 1)
// onto a single data-memory port with one outstanding command at a time.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    dmem_state_e       state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic              ir_q, ir_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        err_q, err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_ir;

    dmem_rr_arb2 u_rr (
        .req    ({p1_req, p0_req}),
        .ptr    (ptr_q),
        .winner (winner)
    );

    assign sel_we    = winner ? p1_we    : p0_we;
    assign sel_addr  = winner ? p1_addr  : p0_addr;
    assign sel_wdata = winner ? p1_wdata : p0_wdata;
    assign sel_ir    = (sel_addr < ADDR_W'(MEM_DEPTH));

    // Next state plus next value of every registered output.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        we_d        = we_q;
        ir_d        = ir_q;
        gnt_d       = 2'b00;
        rvalid_d    = 2'b00;
        err_d       = 2'b00;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d        = ISSUE;
                    ptr_d          = winner;
                    win_d          = winner;
                    we_d           = sel_we;
                    ir_d           = sel_ir;
                    gnt_d[winner]  = 1'b1;
                    err_d[winner]  = sel_we & ~sel_ir;
                    mem_addr_d     = sel_addr;
                    mem_wdata_d    = sel_wdata;
                    mem_write_d    = sel_we & sel_ir;
                    mem_read_d     = ~sel_we & sel_ir;
                end
            end
            ISSUE: begin
                state_d = we_q ? IDLE : RESP;
            end
            RESP: begin
                state_d         = IDLE;
                rvalid_d[win_q] = 1'b1;
                err_d[win_q]    = ~ir_q;
                if (win_q) begin
                    rdata1_d = ir_q ? mem_rdata : '0;
                end else begin
                    rdata0_d = ir_q ? mem_rdata : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b1;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            ir_q        <= 1'b0;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            err_q       <= 2'b00;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            we_q        <= we_d;
            ir_q        <= ir_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign p0_gnt    = gnt_q[0];
    assign p1_gnt    = gnt_q[1];
    assign p0_rvalid = rvalid_q[0];
    assign p1_rvalid = rvalid_q[1];
    assign p0_err    = err_q[0];
    assign p1_err    = err_q[1];
    assign p0_rdata  = rdata0_q;
    assign p1_rdata  = rdata1_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a small behavioural memory and
// a transaction-level reference model (round-robin order, shadow memory).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    int          errors = 0;
    int          checks = 0;
    logic        last_gnt;
    logic [15:0] shadow [16];
    logic [15:0] envmem [16];

    dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory stand-in: write at the edge ending a write cycle, rdata updated at the edge ending a read cycle.
    always @(posedge clk) begin
        if (mem_write) envmem[mem_addr[3:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= envmem[mem_addr[3:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_reqs();
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        last_gnt = 1'b1;
    endtask

    task automatic test_reset();
        logic [67:0] outs;
        #2;
        outs = {p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_read, mem_write,
                p0_rdata, p1_rdata, mem_addr, mem_wdata[11:0]};
        checks++;
        if (outs !== 68'h0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h exp 0", outs);
        end
        checks++;
        if (mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_wdata: got %h exp 0000", mem_wdata);
        end
        tick();
        rst = 1'b1;
        last_gnt = 1'b1;
        tick();
        checks++;
        if ({p0_gnt, p1_gnt, mem_read, mem_write} !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle: gnt/mem=%b exp 0000", {p0_gnt, p1_gnt, mem_read, mem_write});
        end
    endtask

    task automatic test_write();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0004; p0_wdata = 16'h1234;
        tick();
        drop_reqs();
        checks++;
        if ({p1_gnt, p0_gnt, mem_write, mem_read} !== 4'b0110) begin
            errors++;
            $display("FAIL write_gnt: gnt1,gnt0,wr,rd=%b exp 0110", {p1_gnt, p0_gnt, mem_write, mem_read});
        end
        checks++;
        if (mem_addr !== 16'h0004 || mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL write_bus: addr=%h wdata=%h exp 0004 1234", mem_addr, mem_wdata);
        end
        shadow[4] = 16'h1234;
        last_gnt = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            tick();
            checks++;
            if ({p0_gnt, p0_rvalid, p0_err, mem_write} !== 4'b0) begin
                errors++;
                $display("FAIL write_after c%0d: gnt,rvalid,err,wr=%b exp 0000", c,
                         {p0_gnt, p0_rvalid, p0_err, mem_write});
            end
        end
    endtask

    task automatic test_read();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0000; p0_wdata = 16'h2BCD;
        tick();
        drop_reqs();
        shadow[0] = 16'h2BCD;
        last_gnt = 1'b0;
        tick();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0000; p1_wdata = 16'hFFFF;
        tick();
        drop_reqs();
        checks++;
        if ({p1_gnt, p0_gnt, mem_read, mem_write} !== 4'b1010 || mem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL read_gnt: gnt1,gnt0,rd,wr=%b addr=%h exp 1010 0000",
                     {p1_gnt, p0_gnt, mem_read, mem_write}, mem_addr);
        end
        tick();
        checks++;
        if ({p1_rvalid, p1_gnt, mem_read} !== 3'b0) begin
            errors++;
            $display("FAIL read_c2: rvalid,gnt,rd=%b exp 000", {p1_rvalid, p1_gnt, mem_read});
        end
        tick();
        checks++;
        if ({p1_rvalid, p0_rvalid, p1_err} !== 3'b100 || p1_rdata !== 16'h2BCD) begin
            errors++;
            $display("FAIL read_c3: rv1,rv0,err=%b rdata=%h exp 100 2bcd",
                     {p1_rvalid, p0_rvalid, p1_err}, p1_rdata);
        end
        last_gnt = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt, exp_rv;
        logic [15:0] exp_data;
        do_reset();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0004;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0000;
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_gnt = (c % 3 == 1) ? ((((c - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_rv  = (c % 3 == 0) ? ((((c - 3) / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            if (c == 12) drop_reqs();
            checks++;
            if ({p1_gnt, p0_gnt} !== exp_gnt || {p1_rvalid, p0_rvalid} !== exp_rv) begin
                errors++;
                $display("FAIL rr_c%0d: gnt=%b rvalid=%b exp %b %b", c,
                         {p1_gnt, p0_gnt}, {p1_rvalid, p0_rvalid}, exp_gnt, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                exp_data = exp_rv[0] ? shadow[4] : shadow[0];
                checks++;
                if ((exp_rv[0] ? p0_rdata : p1_rdata) !== exp_data || p0_rdata !== shadow[4]) begin
                    errors++;
                    $display("FAIL rr_data_c%0d: p0=%h p1=%h exp %h (p0 hold %h)", c,
                             p0_rdata, p1_rdata, exp_data, shadow[4]);
                end
            end
        end
        last_gnt = 1'b1;
    endtask

    task automatic test_out_of_range();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'hFF94;
        tick();
        drop_reqs();
        checks++;
        if ({p0_gnt, mem_read, mem_write, p0_err} !== 4'b1000) begin
            errors++;
            $display("FAIL oor_rd_gnt: gnt,rd,wr,err=%b exp 1000", {p0_gnt, mem_read, mem_write, p0_err});
        end
        tick();
        tick();
        checks++;
        if ({p0_rvalid, p0_err} !== 2'b11 || p0_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL oor_rd_resp: rvalid,err=%b rdata=%h exp 11 0000", {p0_rvalid, p0_err}, p0_rdata);
        end
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0010; p0_wdata = 16'hDEAD;
        tick();
        drop_reqs();
        checks++;
        if ({p0_gnt, p0_err, mem_write, mem_read} !== 4'b1100) begin
            errors++;
            $display("FAIL oor_wr: gnt,err,wr,rd=%b exp 1100", {p0_gnt, p0_err, mem_write, mem_read});
        end
        tick();
        last_gnt = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [68:0] outs;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0000;
        tick();
        drop_reqs();
        checks++;
        if (p1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: p1_gnt=%b exp 1", p1_gnt);
        end
        tick();
        rst = 1'b0;
        #1;
        outs = {p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err, mem_read, mem_write,
                p0_rdata, p1_rdata, mem_addr, mem_wdata[12:0]};
        checks++;
        if (outs !== 69'h0) begin
            errors++;
            $display("FAIL rstmid_async: outputs=%h exp 0", outs);
        end
        tick();
        rst = 1'b1;
        last_gnt = 1'b1;
        tick();
        checks++;
        if ({p1_rvalid, p0_rvalid, p1_gnt, p0_gnt, mem_read} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_abort: rv1,rv0,g1,g0,rd=%b exp 00000",
                     {p1_rvalid, p0_rvalid, p1_gnt, p0_gnt, mem_read});
        end
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 16'h0004;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 16'h0000;
        tick();
        drop_reqs();
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_first_tie: gnt=%b exp 01", {p1_gnt, p0_gnt});
        end
        tick();
        tick();
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== shadow[4]) begin
            errors++;
            $display("FAIL rstmid_read: rvalid=%b rdata=%h exp 1 %h", p0_rvalid, p0_rdata, shadow[4]);
        end
        last_gnt = 1'b0;
    endtask

    task automatic test_random();
        logic        we_a [2];
        logic [15:0] addr_a [2];
        logic [15:0] wd_a [2];
        logic [1:0]  pat, onehot;
        logic        win, ir;
        logic [15:0] exp_rd, got_rd;
        for (int n = 0; n < 40; n++) begin
            pat = 2'($urandom_range(1, 3));
            for (int p = 0; p < 2; p++) begin
                we_a[p]   = 1'($urandom_range(0, 1));
                addr_a[p] = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(16, 65535))
                                                        : 16'($urandom_range(0, 15));
                wd_a[p]   = 16'($urandom);
            end
            p0_req = pat[0]; p0_we = we_a[0]; p0_addr = addr_a[0]; p0_wdata = wd_a[0];
            p1_req = pat[1]; p1_we = we_a[1]; p1_addr = addr_a[1]; p1_wdata = wd_a[1];
            win = (pat == 2'b11) ? ~last_gnt : pat[1];
            last_gnt = win;
            onehot = win ? 2'b10 : 2'b01;
            ir = (addr_a[win] < 16'd16);
            tick();
            drop_reqs();
            checks++;
            if ({p1_gnt, p0_gnt} !== onehot || mem_write !== (we_a[win] & ir) ||
                mem_read !== (~we_a[win] & ir) ||
                {p1_err, p0_err} !== ((we_a[win] & ~ir) ? onehot : 2'b00)) begin
                errors++;
                $display("FAIL rnd_issue n%0d: gnt=%b wr=%b rd=%b err=%b exp gnt %b we %b ir %b", n,
                         {p1_gnt, p0_gnt}, mem_write, mem_read, {p1_err, p0_err}, onehot, we_a[win], ir);
            end
            if (ir) begin
                checks++;
                if (mem_addr !== addr_a[win] || (we_a[win] && mem_wdata !== wd_a[win])) begin
                    errors++;
                    $display("FAIL rnd_bus n%0d: addr=%h wdata=%h exp %h %h", n,
                             mem_addr, mem_wdata, addr_a[win], wd_a[win]);
                end
            end
            if (we_a[win] && ir) shadow[addr_a[win][3:0]] = wd_a[win];
            tick();
            checks++;
            if ({p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, mem_read, mem_write} !== 6'b0) begin
                errors++;
                $display("FAIL rnd_c2 n%0d: gnt,rvalid,rd,wr=%b exp 000000", n,
                         {p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, mem_read, mem_write});
            end
            if (!we_a[win]) begin
                tick();
                exp_rd = ir ? shadow[addr_a[win][3:0]] : 16'h0000;
                got_rd = win ? p1_rdata : p0_rdata;
                checks++;
                if ({p1_rvalid, p0_rvalid} !== onehot || got_rd !== exp_rd ||
                    {p1_err, p0_err} !== (ir ? 2'b00 : onehot)) begin
                    errors++;
                    $display("FAIL rnd_resp n%0d: rvalid=%b rdata=%h err=%b exp %b %h ir %b", n,
                             {p1_rvalid, p0_rvalid}, got_rd, {p1_err, p0_err}, onehot, exp_rd, ir);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            shadow[i] = 16'h0000;
            envmem[i] = 16'h0000;
        end
        rst = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = 16'h0; p0_wdata = 16'h0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = 16'h0; p1_wdata = 16'h0;
        last_gnt = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 16, data word width.
REQ-002 SHALL have parameter: ADDR_W, 16, requester address width.
REQ-003 SHALL have parameter: MEM_DEPTH, 16, number of implemented data-memory words; addresses >= MEM_DEPTH are out of range.
REQ-004 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports, N in {0,1}: pN_req  input  1  request, held until pN_gnt.
REQ-007 SHALL have ports: pN_we  input  1  1 = write, 0 = read; pN_addr  input  ADDR_W; pN_wdata  input  DATA_W.
REQ-008 SHALL have ports: pN_gnt  output  1  accept pulse; pN_rvalid  output  1  read-data pulse; pN_rdata  output  DATA_W; pN_err  output  1  out-of-range pulse.
REQ-009 SHALL have ports: mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_read  output  1; mem_write  output  1; mem_rdata  input  DATA_W (memory updates it at the edge ending a mem_read cycle).
REQ-010 SHALL drive port 0 from the pipeline MEM stage and port 1 from the loader/debug requester.

Function
REQ-011 SHALL implement FSM states IDLE, ISSUE, RESP. All outputs SHALL be registered.
REQ-012 In IDLE at an edge with any pN_req=1: select winner, latch its we/addr/wdata, go to ISSUE. Otherwise stay in IDLE.
REQ-013 Arbitration SHALL be two-way round-robin. On simultaneous requests, the requester not granted last SHALL win. The last-grant pointer SHALL reset to 1, so p0 wins the first tie.
REQ-014 In ISSUE, for exactly one cycle: winner's pN_gnt=1; mem_addr/mem_wdata = latched values; mem_write = we & in_range; mem_read = ~we & in_range.
REQ-015 From ISSUE: a write SHALL go to IDLE; a read SHALL go to RESP.
REQ-016 In RESP, at the edge leaving RESP: capture mem_rdata into winner's pN_rdata (16'h0000 if out of range), pulse pN_rvalid for the following cycle, go to IDLE.
REQ-017 Latency: request seen at edge of cycle 0 -> gnt in cycle 1 -> read rvalid in cycle 3. Write throughput SHALL be one per 2 cycles; read throughput one per 3 cycles.
REQ-018 pN_req SHALL be sampled only in IDLE; requests arriving in ISSUE/RESP wait; a request withdrawn before grant is simply dropped.
REQ-019 Out of range: address[ADDR_W-1:4] != 0 for MEM_DEPTH=16. No mem_read/mem_write SHALL be issued. pN_err SHALL pulse with pN_gnt (write) or with pN_rvalid (read).
REQ-020 pN_rdata SHALL hold its last value between rvalid pulses. mem_addr/mem_wdata SHALL hold their last value when no command is issued.
REQ-021 At most one of mem_read/mem_write, and at most one pN_gnt, SHALL be high in any cycle.

Reset
REQ-022 While rst=0: state=IDLE, pointer=1, all gnt/rvalid/err/mem_read/mem_write=0, pN_rdata/mem_addr/mem_wdata=0, independent of clk.
REQ-023 Reset asserted mid-transaction SHALL abort it without a memory access or pulse; the first arbitration after release SHALL follow REQ-013.

Structure
REQ-024 The shared package dmem_arb_pkg SHALL hold the FSM state enum, DATA_W/ADDR_W/MEM_DEPTH defaults, and the request-record typedef {we, addr, wdata}.
REQ-025 The two-way round-robin picker SHALL be one sub-module, dmem_rr_arb2 (inputs req[1:0], ptr; output winner). The rest SHALL be flat.

Verification
REQ-026 p0 write addr 16'h0004 data 16'h1234 -> p0_gnt in cycle 1 with mem_write=1, addr 4, wdata 16'h1234; no rvalid.
REQ-027 p1 read addr 16'h0000 with memory holding 16'h2BCD -> p1_gnt cycle 1, mem_read cycle 1, p1_rvalid cycle 3, p1_rdata=16'h2BCD.
REQ-028 p0 and p1 both hold read requests continuously after reset -> grant order p0, p1, p0, p1; each rvalid goes to the correct port only.
REQ-029 p0 read addr 16'hFF94 -> gnt, no mem_read, p0_rvalid with p0_err=1 and p0_rdata=16'h0000.
REQ-030 rst pulsed low during RESP of a p1 read -> no p1_rvalid; all outputs 0. Next simultaneous request grants p0.
